// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: bubble word, fetch FSM states, IF/ID bundle,
// and the fetch-address legality check.
package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Word-aligned and inside the instruction memory; 33-bit compare avoids overflow.
  function automatic logic fetch_addr_ok(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < (33'(words) << 2));
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register with hold (stall) and bubble (flush) controls.
// Flush takes precedence over hold; a bubble keeps the pc fields.
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg.pc    <= 32'd0;
      q_reg.pc4   <= 32'd4;
      q_reg.instr <= BUBBLE_INSTR;
      q_reg.valid <= 1'b0;
    end else if (flush) begin
      q_reg.instr <= BUBBLE_INSTR;
      q_reg.valid <= 1'b0;
    end else if (!hold) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// fills IF/ID, with stall, redirect, halt and sticky fetch-fault handling.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = rv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  import rv_pipe_pkg::*;

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic         fault_reg;
  logic [31:0]  fault_pc_reg;
  logic [31:0]  count_reg;

  logic [31:0]  pc4_next;
  logic         seq_ok;
  logic         target_ok;
  logic         ifid_flush;
  logic         ifid_hold;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign pc4_next  = pc_reg + 32'd4;
  assign seq_ok    = (pc_reg != 32'hFFFF_FFFC) && fetch_addr_ok(pc4_next, IMEM_WORDS);
  assign target_ok = fetch_addr_ok(redirect_target, IMEM_WORDS);

  assign ifid_d.pc    = pc_reg;
  assign ifid_d.pc4   = pc4_next;
  assign ifid_d.instr = imem_instr;
  assign ifid_d.valid = 1'b1;

  // Outside RUN, and on any redirect or halt, IF/ID only ever sees bubbles.
  always_comb begin
    ifid_flush = 1'b1;
    ifid_hold  = 1'b0;
    if (state_reg == RUN && !redirect && !halt_req) begin
      ifid_flush = 1'b0;
      ifid_hold  = stall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      fault_reg    <= 1'b0;
      fault_pc_reg <= 32'd0;
      count_reg    <= 32'd0;
    end else begin
      case (state_reg)
        RUN, HALTED: begin
          if (redirect) begin
            if (target_ok) begin
              pc_reg    <= redirect_target;
              state_reg <= RUN;
            end else begin
              state_reg    <= FAULT;
              fault_reg    <= 1'b1;
              fault_pc_reg <= redirect_target;
            end
          end else if (state_reg == RUN) begin
            if (halt_req) begin
              state_reg <= HALTED;
            end else if (!stall) begin
              // The current word is delivered even when its successor is illegal.
              count_reg <= count_reg + 32'd1;
              if (seq_ok) begin
                pc_reg <= pc4_next;
              end else begin
                state_reg    <= FAULT;
                fault_reg    <= 1'b1;
                fault_pc_reg <= pc4_next;
              end
            end
          end
        end
        FAULT: begin
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .reset(reset),
    .hold (ifid_hold),
    .flush(ifid_flush),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign imem_pc     = pc_reg;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_instr = ifid_q.instr;
  assign if_id_valid = ifid_q.valid;
  assign fetch_fault = fault_reg;
  assign fault_pc    = fault_pc_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: linear steps, each check is an immediate assertion.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  // Memory word i holds 0x0100_0000 + i, except the two program words at 0 and 4.
  assign imem_instr = (imem_pc < 32'h1000) ? mem[imem_pc[11:2]] : 32'hDEAD_BEEF;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(1024),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0100_0000 + 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0; halt_req = 1'b0;
    step(); step();
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_ifid_pc", if_id_pc, 32'h0);
    chk("rst_ifid_pc4", if_id_pc4, 32'h4);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    $display("reset: imem_pc=%h valid=%0d count=%0d", imem_pc, if_id_valid, fetch_count);

    reset = 1'b0;
    step();
    chk("c1_pc", if_id_pc, 32'h0);
    chk("c1_instr", if_id_instr, 32'h0050_0093);
    chk("c1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("c1_imem_pc", imem_pc, 32'h4);
    $display("fetch: if_id_pc=%h instr=%h valid=%0d", if_id_pc, if_id_instr, if_id_valid);
    step();
    chk("c2_pc", if_id_pc, 32'h4);
    chk("c2_pc4", if_id_pc4, 32'h8);
    chk("c2_instr", if_id_instr, 32'h00A0_0113);
    chk("c2_count", fetch_count, 32'd2);
    $display("fetch: if_id_pc=%h instr=%h count=%0d", if_id_pc, if_id_instr, fetch_count);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_imem_pc", imem_pc, 32'h8);
      chk("stall_ifid_pc", if_id_pc, 32'h4);
      chk("stall_count", fetch_count, 32'd2);
      $display("stall: imem_pc=%h if_id_pc=%h count=%0d", imem_pc, if_id_pc, fetch_count);
    end
    stall = 1'b0;
    step();
    chk("resume_pc", if_id_pc, 32'h8);
    chk("resume_instr", if_id_instr, 32'h0100_0002);
    chk("resume_count", fetch_count, 32'd3);
    chk("resume_imem_pc", imem_pc, 32'hC);
    $display("resume: if_id_pc=%h instr=%h count=%0d", if_id_pc, if_id_instr, fetch_count);

    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    step();
    chk("redir_imem_pc", imem_pc, 32'h40);
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_instr", if_id_instr, NOP);
    chk("redir_count", fetch_count, 32'd3);
    $display("redirect: imem_pc=%h valid=%0d instr=%h", imem_pc, if_id_valid, if_id_instr);
    stall = 1'b0; redirect = 1'b0;
    step();
    chk("redir2_pc", if_id_pc, 32'h40);
    chk("redir2_pc4", if_id_pc4, 32'h44);
    chk("redir2_instr", if_id_instr, 32'h0100_0010);
    chk("redir2_valid", {31'd0, if_id_valid}, 32'd1);
    chk("redir2_count", fetch_count, 32'd4);
    $display("after redirect: if_id_pc=%h instr=%h count=%0d", if_id_pc, if_id_instr, fetch_count);

    redirect = 1'b1; redirect_target = 32'h10;
    step();
    redirect = 1'b0; halt_req = 1'b1;
    chk("pre_halt_imem_pc", imem_pc, 32'h10);
    step();
    halt_req = 1'b0; stall = 1'b1;
    chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
    chk("halt_imem_pc", imem_pc, 32'h10);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("halted_imem_pc", imem_pc, 32'h10);
      chk("halted_valid", {31'd0, if_id_valid}, 32'd0);
      chk("halted_count", fetch_count, 32'd4);
      $display("halted: imem_pc=%h valid=%0d", imem_pc, if_id_valid);
    end
    stall = 1'b0; redirect = 1'b1; redirect_target = 32'h20;
    step();
    redirect = 1'b0;
    chk("unhalt_imem_pc", imem_pc, 32'h20);
    chk("unhalt_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("unhalt_pc", if_id_pc, 32'h20);
    chk("unhalt_instr", if_id_instr, 32'h0100_0008);
    chk("unhalt_valid2", {31'd0, if_id_valid}, 32'd1);
    chk("unhalt_count", fetch_count, 32'd5);
    $display("trap return: if_id_pc=%h instr=%h count=%0d", if_id_pc, if_id_instr, fetch_count);

    redirect = 1'b1; redirect_target = 32'hFF8;
    step();
    redirect = 1'b0;
    chk("edge_imem_pc", imem_pc, 32'hFF8);
    step();
    chk("edge_ffc_pc", if_id_pc, 32'hFF8);
    chk("edge_imem_pc2", imem_pc, 32'hFFC);
    chk("edge_count", fetch_count, 32'd6);
    step();
    chk("last_pc", if_id_pc, 32'hFFC);
    chk("last_instr", if_id_instr, 32'h0100_03FF);
    chk("last_valid", {31'd0, if_id_valid}, 32'd1);
    chk("last_count", fetch_count, 32'd7);
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_fault_pc", fault_pc, 32'h1000);
    chk("oor_imem_pc", imem_pc, 32'hFFC);
    $display("end of memory: if_id_pc=%h fault=%0d fault_pc=%h", if_id_pc, fetch_fault, fault_pc);
    step();
    chk("oor_bubble", {31'd0, if_id_valid}, 32'd0);
    chk("oor_count", fetch_count, 32'd7);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst2_imem_pc", imem_pc, 32'h0);
    chk("rst2_count", fetch_count, 32'd0);
    step();
    chk("rst2_fetch_pc", if_id_pc, 32'h0);
    chk("rst2_fetch_valid", {31'd0, if_id_valid}, 32'd1);
    $display("reset from fault: if_id_pc=%h valid=%0d", if_id_pc, if_id_valid);

    redirect = 1'b1; redirect_target = 32'h42;
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h42);
    chk("mis_imem_pc", imem_pc, 32'h4);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    $display("misaligned: fault=%0d fault_pc=%h imem_pc=%h", fetch_fault, fault_pc, imem_pc);
    redirect_target = 32'h80;
    step();
    redirect = 1'b0;
    chk("frozen_fault_pc", fault_pc, 32'h42);
    chk("frozen_imem_pc", imem_pc, 32'h4);
    chk("frozen_valid", {31'd0, if_id_valid}, 32'd0);
    chk("frozen_count", fetch_count, 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0; redirect = 1'b1; redirect_target = 32'h1000;
    step();
    redirect = 1'b0;
    chk("oor_tgt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_tgt_fault_pc", fault_pc, 32'h1000);
    chk("oor_tgt_imem_pc", imem_pc, 32'h0);
    $display("out-of-range target: fault=%0d fault_pc=%h", fetch_fault, fault_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch initiator for the RV32IM 5-stage pipeline.
- Owns the program counter and drives the fetch address to the instruction memory.
- The instruction memory returns the addressed word on the falling edge of the same cycle.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, halt and fetch-fault conditions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 1024, number of 32-bit words in instruction memory; a PC at or beyond IMEM_WORDS*4 is out of range.
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on flush/halt/fault.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
reset  input  1  synchronous, active-high.
imem_pc  output  32  fetch address to instruction memory; equals internal PC.
imem_instr  input  32  word returned by instruction memory, valid before the next rising edge.
stall  input  1  hazard unit: hold PC and IF/ID contents.
redirect  input  1  EX-stage branch taken / jump: load redirect_target, flush IF/ID.
redirect_target  input  32  new PC on redirect.
halt_req  input  1  decode saw ecall/ebreak: stop fetching.
if_id_pc  output  32  PC of instruction held in IF/ID.
if_id_pc4  output  32  if_id_pc + 4.
if_id_instr  output  32  instruction held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction.
fetch_fault  output  1  sticky; misaligned or out-of-range fetch detected.
fault_pc  output  32  offending address, latched on fault.
fetch_count  output  32  number of valid instructions delivered to IF/ID.

Behaviour:
- Reset values:
  - PC = RESET_PC.
  - if_id_pc = 0; if_id_pc4 = 4; if_id_instr = NOP_INSTR; if_id_valid = 0.
  - fetch_fault = 0; fault_pc = 0; fetch_count = 0; state = RUN.
- Latency: the word at PC is captured into IF/ID at the rising edge ending the cycle in which imem_pc = PC. A valid instruction appears one cycle after reset deasserts; no boot bubble.
- FSM states: RUN, HALTED, FAULT.
- RUN, per rising edge, priority: reset > redirect > halt_req > stall > sequential.
  - redirect: PC <= redirect_target; IF/ID <= bubble (instr=NOP_INSTR, valid=0). Applies even when stall=1. If the target is misaligned (bits[1:0] != 0) or out of range: go to FAULT, fetch_fault <= 1, fault_pc <= target, PC unchanged.
  - halt_req (no redirect): IF/ID <= bubble; PC held; go to HALTED.
  - stall: PC and all IF/ID outputs held; fetch_count unchanged.
  - sequential: IF/ID <= {PC, PC+4, imem_instr, valid=1}; PC <= PC+4; fetch_count += 1 (wraps modulo 2^32).
  - If the sequential next PC is out of range: IF/ID still captures the current word; then go to FAULT with fault_pc = PC+4, PC held.
- HALTED:
  - IF/ID holds bubble; PC held.
  - Only redirect leaves HALTED (to RUN, with the same fault checks). Handles trap return.
  - stall and halt_req are ignored.
- FAULT:
  - IF/ID holds bubble; PC, fault_pc and fetch_fault frozen.
  - Only reset exits.
- imem_pc is always the registered PC (never combinational from redirect).
- if_id_pc4 is registered together with if_id_pc (no wrap check beyond 32-bit addition).
- Reset mid-stall/halt/fault returns to RUN at RESET_PC with IF/ID invalid.

Decomposition:
- Shared package rv_pipe_pkg:
  - NOP_INSTR constant and fetch FSM state enum (RUN, HALTED, FAULT).
  - IF/ID bundle typedef {pc, pc4, instr, valid}.
- One natural sub-module: if_id_reg. It is the pipeline register with hold (stall) and bubble (flush) controls, and is reused by the later stage registers.
- PC logic and FSM stay in the top.

Test Plan:
- Reset release, memory words 0x00500093, 0x00A00113 at 0, 4, no stall → cycle1 IF/ID = {pc=0, instr=0x00500093, valid=1}; cycle2 = {pc=4, instr=0x00A00113}; fetch_count=2.
- stall high for 3 cycles at PC=8 → imem_pc stays 8; IF/ID frozen at pc=4; fetch_count unchanged; fetching resumes at 8.
- redirect=1 with target=0x40 while stall=1 → next cycle imem_pc=0x40, if_id_valid=0, if_id_instr=0x00000013; following cycle IF/ID pc=0x40 valid.
- redirect to 0x42 → fetch_fault=1, fault_pc=0x42, IF/ID bubble persists; further redirects ignored until reset clears all.
- Sequential fetch reaching PC=0xFFC (IMEM_WORDS=1024) → word at 0xFFC delivered valid; then fetch_fault=1, fault_pc=0x1000.
- halt_req at PC=0x10 → HALTED: bubbles, PC held at 0x10 for 5 cycles; redirect to 0x20 → RUN, IF/ID pc=0x20 valid next cycle.
